// File: rtl/xrad_mac_sched.sv
// Round-robin scheduler sharing one XRAD complex MAC among NUM_REQ job requesters.
// One job at a time: clear accumulator, stream LEN operand reads, capture the packed result.
module xrad_mac_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int LEN_W   = 10,
  parameter  int RD_LAT  = 1,
  parameter  int MAC_LAT = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rd_en,
  output logic [ID_W-1:0]          rd_sel,
  output logic [LEN_W-1:0]         rd_addr,
  output logic                     mac_clr,
  output logic                     mac_en,
  input  logic [31:0]              mac_result,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id,
  output logic [31:0]              done_result,
  input  logic                     done_ready
);

  // state | meaning
  // IDLE  | waiting for any request; grant issued combinationally
  // CLR   | one-cycle accumulator clear pulse
  // ISSUE | one operand read per cycle, addr 0..len-1
  // DRAIN | wait for read + MAC pipeline to deliver the last product
  // DONE  | result presented until the consumer takes it
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLR   = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Drain spans RD_LAT+MAC_LAT-1 cycles; capture happens in its last cycle.
  localparam logic [2:0] DRAIN_INIT = 3'(RD_LAT + MAC_LAT - 2);

  logic [1:0]        rst_sync;
  logic              rst_int_n;
  logic [2:0]        state;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  addr_q;
  logic [2:0]        drain_cnt;
  logic [ID_W-1:0]   rr_ptr;
  logic [RD_LAT-1:0] en_sr;
  logic [ID_W-1:0]   done_id_q;
  logic [31:0]       done_res_q;

  logic              gnt_any;
  logic [ID_W-1:0]   gnt_id;
  logic [LEN_W-1:0]  gnt_len;
  logic [ID_W-1:0]   rr_next;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  assign gnt_len = req_len[int'(gnt_id)*LEN_W +: LEN_W];
  assign rr_next = (int'(gnt_id) == NUM_REQ-1) ? '0 : gnt_id + ID_W'(1);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state      <= IDLE;
      id_q       <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      drain_cnt  <= '0;
      rr_ptr     <= '0;
      en_sr      <= '0;
      done_id_q  <= '0;
      done_res_q <= '0;
    end else begin
      en_sr[0] <= (state == ISSUE);
      for (int i = 1; i < RD_LAT; i++) en_sr[i] <= en_sr[i-1];

      case (state)
        IDLE: begin
          if (gnt_any) begin
            id_q       <= gnt_id;
            len_q      <= gnt_len;
            addr_q     <= '0;
            rr_ptr     <= rr_next;
            done_id_q  <= gnt_id;
            done_res_q <= '0;
            state      <= (gnt_len == '0) ? DONE : CLR;
          end
        end
        CLR: state <= ISSUE;
        ISSUE: begin
          if (addr_q == len_q - LEN_W'(1)) begin
            drain_cnt <= DRAIN_INIT;
            state     <= DRAIN;
          end else begin
            addr_q <= addr_q + LEN_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            done_res_q <= mac_result;
            state      <= DONE;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        DONE:    if (done_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready   = (rst_int_n && state == IDLE && gnt_any) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign rd_en       = (state == ISSUE);
  assign rd_sel      = rd_en ? id_q : '0;
  assign rd_addr     = rd_en ? addr_q : '0;
  assign mac_clr     = (state == CLR);
  assign mac_en      = en_sr[RD_LAT-1];
  assign done_valid  = (state == DONE);
  assign done_id     = done_id_q;
  assign done_result = done_res_q;

endmodule

// File: tb/tb_xrad_mac_sched.sv
// Scoreboard bench for xrad_mac_sched with a behavioural operand memory and complex MAC.
module tb_xrad_mac_sched;
  localparam int NUM_REQ = 4;
  localparam int LEN_W   = 10;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rd_en;
  logic [1:0]               rd_sel;
  logic [LEN_W-1:0]         rd_addr;
  logic                     mac_clr;
  logic                     mac_en;
  logic [31:0]              mac_result;
  logic                     done_valid;
  logic [1:0]               done_id;
  logic [31:0]              done_result;
  logic                     done_ready;

  xrad_mac_sched #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .RD_LAT(1), .MAC_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_result(mac_result), .done_valid(done_valid), .done_id(done_id),
    .done_result(done_result), .done_ready(done_ready));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memory contents as a function of bank and index.
  function automatic int a_re(int s, int a); return 256*(s+1) + a; endfunction
  function automatic int a_im(int s, int a); return 100 - 3*a + s; endfunction
  function automatic int w_re(int s, int a); return 300 + 7*a - s; endfunction
  function automatic int w_im(int s, int a); return a - 50*s; endfunction

  function automatic logic [31:0] ref_res(int s, int len);
    int re, im;
    logic [31:0] ur, ui;
    re = 0; im = 0;
    for (int a = 0; a < len; a++) begin
      re += a_re(s,a)*w_re(s,a) - a_im(s,a)*w_im(s,a);
      im += a_re(s,a)*w_im(s,a) + a_im(s,a)*w_re(s,a);
    end
    ur = re; ui = im;
    return {ur[31:16], ui[31:16]};
  endfunction

  // Behavioural MAC: 1-cycle memory, product register, accumulator.
  int d_sel, d_addr, prod_re, prod_im, acc_re, acc_im, sum_re, sum_im;
  logic pv;
  always @(posedge clk) begin
    if (rd_en) begin d_sel <= int'(rd_sel); d_addr <= int'(rd_addr); end
    if (mac_en) begin
      prod_re <= a_re(d_sel,d_addr)*w_re(d_sel,d_addr) - a_im(d_sel,d_addr)*w_im(d_sel,d_addr);
      prod_im <= a_re(d_sel,d_addr)*w_im(d_sel,d_addr) + a_im(d_sel,d_addr)*w_re(d_sel,d_addr);
    end
    pv <= mac_en;
    if (mac_clr) begin acc_re <= 0; acc_im <= 0; end
    else if (pv) begin acc_re <= acc_re + prod_re; acc_im <= acc_im + prod_im; end
  end
  always_comb begin
    sum_re = acc_re + (pv ? prod_re : 0);
    sum_im = acc_im + (pv ? prod_im : 0);
    mac_result = {sum_re[31:16], sum_im[31:16]};
  end

  typedef struct { int id; int len; logic [31:0] res; int lat; } job_t;
  job_t exp_job[$];
  int   exp_gnt[$];

  int gnt_cnt = 0, done_cnt = 0;
  int grant_cyc, rd_cnt, clr_cnt, exp_addr, cur_id;
  logic prev_rd = 1'b0, prev_dv = 1'b0;

  // Monitor: compares every grant, read, and result against the queued expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rd = 1'b0; prev_dv = 1'b0;
    end else begin
      if (req_ready != '0) begin
        int gid; gid = 0;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
        tests++;
        if (exp_gnt.size() == 0) begin
          fails++; $display("FAIL grant_unexpected req_ready=%b", req_ready);
        end else begin
          int e; e = exp_gnt.pop_front();
          if ($countones(req_ready) != 1 || gid != e || !req_valid[gid]) begin
            fails++; $display("FAIL grant_id got req_ready=%b expected id %0d", req_ready, e);
          end
        end
        gnt_cnt++; grant_cyc = cyc; rd_cnt = 0; clr_cnt = 0; exp_addr = 0; cur_id = gid;
      end
      if (mac_clr) clr_cnt++;
      if (rd_en) begin
        tests++;
        if (int'(rd_addr) != exp_addr || int'(rd_sel) != cur_id) begin
          fails++; $display("FAIL rd_seq got sel=%0d addr=%0d expected sel=%0d addr=%0d",
                            rd_sel, rd_addr, cur_id, exp_addr);
        end
        exp_addr++; rd_cnt++;
      end
      if (mac_en || prev_rd) begin
        tests++;
        if (mac_en != prev_rd) begin
          fails++; $display("FAIL mac_en_lag got %0b expected %0b", mac_en, prev_rd);
        end
      end
      prev_rd = rd_en;
      if (done_valid && !prev_dv) begin
        tests++;
        if (exp_job.size() == 0) begin
          fails++; $display("FAIL done_unexpected id=%0d", done_id);
        end else if (cyc - grant_cyc != exp_job[0].lat || rd_cnt != exp_job[0].len ||
                     clr_cnt != (exp_job[0].len > 0 ? 1 : 0)) begin
          fails++; $display("FAIL done_timing got lat=%0d reads=%0d clr=%0d expected lat=%0d reads=%0d",
                            cyc - grant_cyc, rd_cnt, clr_cnt, exp_job[0].lat, exp_job[0].len);
        end
      end
      if (done_valid && done_ready) begin
        tests++;
        if (exp_job.size() == 0) begin
          fails++; $display("FAIL done_pop_empty id=%0d", done_id);
        end else begin
          job_t j; j = exp_job.pop_front();
          if (int'(done_id) != j.id || done_result != j.res) begin
            fails++; $display("FAIL done_data got id=%0d res=%h expected id=%0d res=%h",
                              done_id, done_result, j.id, j.res);
          end
        end
        done_cnt++;
      end
      prev_dv = done_valid;
    end
  end

  task automatic set_len(int i, int v);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic push_job(int id, int len);
    job_t j;
    j.id = id; j.len = len; j.res = (len == 0) ? 32'h0 : ref_res(id, len);
    j.lat = (len == 0) ? 1 : len + 4;
    exp_gnt.push_back(id);
    exp_job.push_back(j);
  endtask

  task automatic wait_grants(int n, string tag);
    int b; b = 0;
    while (gnt_cnt < n && b < 2000) begin @(posedge clk); b++; end
    #1;
    tests++;
    if (gnt_cnt < n) begin fails++; $display("FAIL timeout_grant %s got %0d expected %0d", tag, gnt_cnt, n); end
  endtask

  task automatic wait_done(int n, string tag);
    int b; b = 0;
    while (done_cnt < n && b < 2000) begin @(posedge clk); b++; end
    #1;
    tests++;
    if (done_cnt < n) begin fails++; $display("FAIL timeout_done %s got %0d expected %0d", tag, done_cnt, n); end
  endtask

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    tests++;
    if (got !== want) begin fails++; $display("FAIL %s got %h expected %h", tag, got, want); end
  endtask

  initial begin
    int b;
    rst_n = 1'b0; req_valid = '0; req_len = '0; done_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {req_ready, rd_en, rd_sel, rd_addr, mac_clr, mac_en, done_valid, done_id, done_result},
          '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // All four requesting, len=1 each: fairness order 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_len(i, 1);
    push_job(0,1); push_job(1,1); push_job(2,1); push_job(3,1); push_job(0,1);
    req_valid = 4'b1111;
    wait_grants(5, "rr");
    req_valid = '0;
    wait_done(5, "rr");

    // Single requester 2, len=4; grant lasts exactly one cycle.
    set_len(2, 4); push_job(2, 4);
    req_valid = 4'b0100;
    @(negedge clk);
    check("t1_grant", 64'(req_ready), 64'(4'b0100));
    @(negedge clk);
    check("t1_one_cycle", 64'({req_ready, mac_clr}), 64'({4'b0000, 1'b1}));
    #1 req_valid = '0;
    wait_done(6, "t1");

    // Zero-length job from requester 1.
    set_len(1, 0); push_job(1, 0);
    req_valid = 4'b0010;
    wait_grants(7, "t3");
    req_valid = '0;
    @(negedge clk);
    check("t3_done_zero", 64'({done_valid, done_id, done_result, rd_en, mac_clr}),
          64'({1'b1, 2'd1, 32'h0, 1'b0, 1'b0}));
    wait_done(7, "t3");

    // Backpressure: result held while requester 3 waits.
    done_ready = 1'b0;
    set_len(2, 2); push_job(2, 2);
    req_valid = 4'b0100;
    wait_grants(8, "t4a");
    set_len(3, 3); push_job(3, 3);
    req_valid = 4'b1000;
    b = 0;
    while (!done_valid && b < 200) begin @(posedge clk); #1; b++; end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_hold", {27'h0, done_valid, done_id, done_result, req_ready},
            {27'h0, 1'b1, 2'd2, ref_res(2,2), 4'b0000});
      @(posedge clk); #1;
    end
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_grant_after", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1 req_valid = '0;
    wait_done(9, "t4");

    // Two back-to-back jobs give independent accumulations.
    set_len(0, 5); set_len(1, 7); push_job(0, 5); push_job(1, 7);
    req_valid = 4'b0011;
    wait_grants(10, "t6a");
    wait_grants(11, "t6b");
    req_valid = '0;
    wait_done(11, "t6");

    // Reset in the middle of a long job.
    set_len(3, 16); push_job(3, 16);
    req_valid = 4'b1000;
    wait_grants(12, "t5a");
    req_valid = '0;
    b = 0;
    @(negedge clk);
    while (!(rd_en && rd_addr == 10'd5) && b < 200) begin @(negedge clk); b++; end
    check("t5_reached_addr5", 64'({rd_en, rd_addr}), 64'({1'b1, 10'd5}));
    rst_n = 1'b0;
    exp_job.delete(); exp_gnt.delete();
    set_len(0, 3); req_valid = 4'b0001;
    #1;
    check("t5_abort_outputs", {req_ready, rd_en, rd_sel, rd_addr, mac_clr, mac_en, done_valid, done_id, done_result},
          '0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_held_outputs", {req_ready, rd_en, rd_sel, rd_addr, mac_clr, mac_en, done_valid, done_id, done_result},
          '0);
    push_job(0, 3);
    rst_n = 1'b1;
    wait_grants(13, "t5b");
    req_valid = '0;
    wait_done(12, "t5");
    repeat (5) @(posedge clk);
    #1;
    check("final_queues_empty", 64'(exp_job.size() + exp_gnt.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
